serial_to_parallel_rx: RTL and testbench

- Receive-side counterpart of the team's 4-bit universal shift register, which loads a parallel word and shifts it out serially.
- Accepts one serial bit per accepted handshake, MSB-first or LSB-first, and assembles WIDTH-bit words.
- Presents each completed word on a valid/ready parallel output port, holding one buffered word.
- Provides a sync input for word alignment and a sticky fragment-error flag.

---
 rtl/serial_to_parallel_rx.sv | 63 ++++++
 tb/tb_serial_to_parallel_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx: assembles serial bits (MSB- or LSB-first) into WIDTH-bit words
// behind a one-word valid/ready buffer, with sync realignment and a sticky fragment error.
module serial_to_parallel_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic             s_data,
    input  logic             s_dir,
    output logic             s_ready,
    input  logic             sync,
    input  logic             err_clr,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             frag_err
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] nxt;
    logic             dir_q;
    logic             dir_eff;
    logic             last;
    logic             accept;

    assign last    = cnt == CW'(WIDTH - 1);
    assign s_ready = !sync && !(last && p_valid && !p_ready);
    assign accept  = s_valid && s_ready;
    // Direction comes straight from s_dir on the first bit, then from the latched copy.
    assign dir_eff = (cnt == '0) ? s_dir : dir_q;
    assign nxt     = dir_eff ? {s_data, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], s_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            sr       <= '0;
            dir_q    <= 1'b0;
            p_data   <= '0;
            p_valid  <= 1'b0;
            frag_err <= 1'b0;
        end else begin
            frag_err <= (sync && cnt != '0) ? 1'b1 : err_clr ? 1'b0 : frag_err;
            if (sync) begin
                cnt <= '0;
                sr  <= '0;
            end else if (accept) begin
                sr  <= nxt;
                cnt <= last ? '0 : cnt + 1'b1;
                if (cnt == '0)
                    dir_q <= s_dir;
                if (last)
                    p_data <= nxt;
            end
            if (accept && last)
                p_valid <= 1'b1;
            else if (p_ready)
                p_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb_serial_to_parallel_rx: directed plan plus random traffic, checked every cycle
// against a bit-queue reference model of the receiver.
module tb_serial_to_parallel_rx;
    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0, s_data = 1'b0, s_dir = 1'b0;
    logic             sync = 1'b0, err_clr = 1'b0, p_ready = 1'b0;
    logic             s_ready, p_valid, frag_err;
    logic [WIDTH-1:0] p_data;

    int vectors = 0;
    int miscompares = 0;

    serial_to_parallel_rx #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_dir(s_dir),
        .s_ready(s_ready), .sync(sync), .err_clr(err_clr), .p_data(p_data),
        .p_valid(p_valid), .p_ready(p_ready), .frag_err(frag_err)
    );

    always #5 clk = ~clk;

    // Reference model: partial word kept as a queue of received bits.
    logic             m_q[$];
    logic             m_dir;
    logic [WIDTH-1:0] m_pdata;
    logic             m_pvalid;
    logic             m_frag;

    function automatic logic exp_ready();
        return !sync && !(m_q.size() == WIDTH - 1 && m_pvalid && !p_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_dir    = 1'b0;
            m_pdata  = '0;
            m_pvalid = 1'b0;
            m_frag   = 1'b0;
        end else begin
            logic acc;
            acc = s_valid && exp_ready();
            if (sync && m_q.size() != 0) m_frag = 1'b1;
            else if (err_clr) m_frag = 1'b0;
            if (sync) m_q.delete();
            if (acc) begin
                if (m_q.size() == 0) m_dir = s_dir;
                m_q.push_back(s_data);
            end
            if (acc && m_q.size() == WIDTH) begin
                for (int i = 0; i < WIDTH; i++)
                    m_pdata[m_dir ? i : WIDTH - 1 - i] = m_q[i];
                m_pvalid = 1'b1;
                m_q.delete();
            end else if (p_ready) begin
                m_pvalid = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always begin
        @(negedge clk);
        if (rst_n) begin
            chk("model p_data", 32'(p_data), 32'(m_pdata));
            chk("model p_valid", 32'(p_valid), 32'(m_pvalid));
            chk("model frag_err", 32'(frag_err), 32'(m_frag));
            #1;
            if (rst_n) chk("model s_ready", 32'(s_ready), 32'(exp_ready()));
        end
    end

    task automatic drive(input logic v, input logic d, input logic dr, input logic sy,
                         input logic ec, input logic pr);
        @(negedge clk);
        s_valid = v; s_data = d; s_dir = dr; sync = sy; err_clr = ec; p_ready = pr;
    endtask

    task automatic idle(input logic pr);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pr);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset p_data", 32'(p_data), 32'h0);
        chk("reset p_valid", 32'(p_valid), 32'h0);
        chk("reset frag_err", 32'(frag_err), 32'h0);
        rst_n = 1'b1;

        // MSB-first 1010
        drive(1, 1, 0, 0, 0, 1); drive(1, 0, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 1); drive(1, 0, 0, 0, 0, 1);
        idle(1);
        chk("msb p_valid", 32'(p_valid), 32'h1);
        chk("msb p_data", 32'(p_data), 32'ha);
        idle(1);
        chk("msb consumed", 32'(p_valid), 32'h0);

        // LSB-first 1010, then with s_dir toggled mid-word
        drive(1, 1, 1, 0, 0, 1); drive(1, 0, 1, 0, 0, 1);
        drive(1, 1, 1, 0, 0, 1); drive(1, 0, 1, 0, 0, 1);
        idle(1);
        chk("lsb p_data", 32'(p_data), 32'h5);
        drive(1, 1, 1, 0, 0, 1); drive(1, 0, 1, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 1); drive(1, 0, 0, 0, 0, 1);
        idle(1);
        chk("lsb dir latched", 32'(p_data), 32'h5);

        // Back-pressure: 1010 then 0101 with p_ready low
        drive(1, 1, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0); drive(1, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0); drive(1, 1, 0, 0, 0, 0);
        #1 chk("bp s_ready low", 32'(s_ready), 32'h0);
        drive(1, 1, 0, 0, 0, 0);
        #1 chk("bp held data", 32'(p_data), 32'ha);
        drive(1, 1, 0, 0, 0, 1);
        #1 chk("bp s_ready high", 32'(s_ready), 32'h1);
        idle(0);
        chk("bp new data", 32'(p_data), 32'h5);
        chk("bp valid kept", 32'(p_valid), 32'h1);
        idle(1);
        idle(1);
        chk("bp drained", 32'(p_valid), 32'h0);

        // Sync mid-word
        drive(1, 1, 0, 0, 0, 1); drive(1, 1, 0, 0, 0, 1);
        drive(1, 1, 0, 1, 0, 1);
        #1 chk("sync s_ready", 32'(s_ready), 32'h0);
        drive(1, 0, 0, 0, 0, 1);
        chk("sync frag set", 32'(frag_err), 32'h1);
        drive(1, 1, 0, 0, 0, 1); drive(1, 0, 0, 0, 0, 1); drive(1, 1, 0, 0, 0, 1);
        idle(1);
        chk("sync realigned", 32'(p_data), 32'h5);
        drive(0, 0, 0, 0, 1, 1);
        idle(1);
        chk("err_clr", 32'(frag_err), 32'h0);
        drive(0, 0, 0, 1, 0, 1);
        idle(1);
        chk("sync idle no err", 32'(frag_err), 32'h0);

        // Async reset mid-word with a buffered word
        drive(1, 1, 0, 0, 0, 0); drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0); drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
        idle(0);
        chk("pre-reset valid", 32'(p_valid), 32'h1);
        chk("pre-reset frag", 32'(frag_err), 32'h0);
        #3 rst_n = 1'b0;
        #1;
        chk("async p_valid", 32'(p_valid), 32'h0);
        chk("async p_data", 32'(p_data), 32'h0);
        chk("async frag_err", 32'(frag_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 1); drive(1, 0, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 1); drive(1, 1, 0, 0, 0, 1);
        idle(1);
        chk("post-reset word", 32'(p_data), 32'h3);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 2) != 0);
        idle(1);
        idle(1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
